seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1): width of the len field.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: x is sampled only when en=1.
REQ-007 Port x, input, 1: serial data bit.
REQ-008 Port cfg_load, input, 1: captures pattern, len and overlap.
REQ-009 Port pattern, input, MAX_LEN: target sequence; bit len-1 is the first bit received, bit 0 the last.
REQ-010 Port len, input, LEN_W: active pattern length.
REQ-011 Port overlap, input, 1: 1 selects the overlapping mode, 0 the non-overlapping mode.
REQ-012 Port cnt_clr, input, 1: synchronous clear of match_cnt and cnt_sat.
REQ-013 Port y, output, 1: registered one-cycle match pulse.
REQ-014 Port match_cnt, output, CNT_W: number of matches detected.
REQ-015 Port cnt_sat, output, 1: sticky flag, set when match_cnt is saturated.

Function
REQ-016 Configuration registers cfg_pat, cfg_len and cfg_ovl SHALL load on cfg_load=1; they hold their values otherwise.
REQ-017 On load, a len above MAX_LEN SHALL be clamped to MAX_LEN; cfg_len=0 SHALL disable detection (y stays 0).
REQ-018 cfg_load SHALL clear the history register and the fill count.
- When cfg_load and en are both 1, cfg_load wins and x is discarded.
REQ-019 On each edge with en=1 and cfg_load=0, the history SHALL update as hist <= {hist[MAX_LEN-2:0], x}.
- fill increments, saturating at MAX_LEN.
REQ-020 A match SHALL be defined as both of:
- fill_next >= cfg_len;
- the low cfg_len bits of hist_next equal the low cfg_len bits of cfg_pat.
REQ-021 y SHALL be registered: it is 1 for exactly the one cycle following the edge that sampled the completing bit.
- y is 0 on all edges with en=0.
REQ-022 When the match completes, matching bits may be reused depending on mode:
- overlap=1: fill is unchanged, so bits may be reused.
- overlap=0: fill resets to 0, so the next match needs cfg_len fresh bits.
REQ-023 Detection SHALL be a history-compare design; there is no per-pattern hard-coded state machine.
- Internal control FSM states: IDLE (cfg_len=0), FILL (fill<cfg_len), ARMED (fill>=cfg_len).
REQ-024 FSM transitions:
- cfg_load goes to IDLE if the clamped len is 0, otherwise to FILL.
- FILL goes to ARMED when fill_next reaches cfg_len.
- ARMED goes to FILL on a non-overlap match.
REQ-025 match_cnt SHALL increment by 1 on each match and saturate at all-ones.
- The edge that reaches all-ones sets cnt_sat.
- Further matches leave match_cnt and cnt_sat unchanged.
REQ-026 cnt_clr SHALL zero match_cnt and cnt_sat and has priority over a simultaneous match; y still pulses.
REQ-027 en=0 SHALL freeze the history, fill, FSM and counter; a bit gap does not break a partial match.

Reset
REQ-028 Asserting rst=0 SHALL immediately clear all state, independent of clk:
- y=0, match_cnt=0, cnt_sat=0;
- hist=0, fill=0, FSM=IDLE;
- cfg_pat=0, cfg_len=0, cfg_ovl=0.
REQ-029 Reset asserted mid-sequence SHALL discard the partial match; detection resumes only after deassertion plus a cfg_load.
REQ-030 Reset deassertion SHALL be assumed synchronous to clk; the block contains no synchronizer.

Structure
REQ-031 A shared package seq_det_pkg SHALL hold:
- the FSM state enum (IDLE/FILL/ARMED);
- default MAX_LEN and CNT_W constants;
- a clamp_len function.
REQ-032 One sub-module, sat_counter (width parameter, inc, clr, cnt, sat), SHALL implement REQ-025 and REQ-026.
- The rest stays in seq_detector_param.

Verification
REQ-033 Pattern 0111, len=4, overlap=0, load.
- Stream 0,1,0,0,1,1,1,1,1,0,1,1,1 gives y pulses after bit 7 and bit 13 only.
- match_cnt=2 at the end.
REQ-034 Pattern 101, len=3.
- Stream 1,0,1,0,1 with overlap=1 gives 2 pulses (after bits 3 and 5).
- The same stream with overlap=0 gives 1 pulse.
REQ-035 Pattern 0111, with en dropped for 3 cycles between bits 2 and 3.
- y still pulses after the 4th enabled bit.
- During en=0, y=0.
REQ-036 CNT_W=2, pattern 1, len=1, stream of five 1s.
- match_cnt reads 1,2,3,3,3.
- cnt_sat rises with the 3rd match.
- cnt_clr together with the 5th match gives match_cnt=0, cnt_sat=0, y=1.
REQ-037 Reset and config boundaries:
- rst=0 pulsed mid-clock after 3 of 4 bits of 0111: all outputs 0 immediately.
- After release without cfg_load, the stream 0111 gives no pulse.
- len=0 load gives no pulses.
- len=MAX_LEN+3 gives a MAX_LEN-bit match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parameterised serial sequence detector:
//   - det_state_t : control FSM state (IDLE / FILL / ARMED)
//   - DEF_MAX_LEN : default maximum pattern length
//   - DEF_CNT_W   : default match-counter width
//   - clamp_len() : limits a requested pattern length to the supported maximum
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no active pattern (cfg_len = 0)
    FILL  = 2'd1,  // fewer than cfg_len bits collected
    ARMED = 2'd2   // enough bits collected to evaluate a match every bit
  } det_state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  function automatic int unsigned clamp_len(input int unsigned req_len,
                                            input int unsigned max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating event counter with a sticky saturation flag.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   inc  - count one event this edge
//   clr  - synchronous clear of cnt and sat, wins over inc
//   cnt  - event count, holds at all-ones
//   sat  - set on the edge that brings cnt to all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic [W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= w_cnt_inc;
      // Flag is raised by the increment that lands on all-ones.
      if (&w_cnt_inc) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-configurable serial pattern detector built around a shift history
// compared against a masked pattern register (no per-pattern state machine).
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset, clears all state
//   en        - sample x on this edge
//   x         - serial data bit
//   cfg_load  - capture pattern/len/overlap, flush history (wins over en)
//   pattern   - target sequence, bit len-1 arrives first, bit 0 last
//   len       - active pattern length (clamped to MAX_LEN, 0 disables)
//   overlap   - 1: completed match bits may be reused, 0: fresh bits needed
//   cnt_clr   - synchronous clear of match_cnt / cnt_sat
//   y         - registered one-cycle match pulse
//   match_cnt - saturating number of matches
//   cnt_sat   - sticky saturation flag
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  logic [MAX_LEN-1:0] r_cfg_pat;
  logic [LEN_W-1:0]   r_cfg_len;
  logic               r_cfg_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  det_state_t         r_state;
  logic               r_y;

  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_armed_next;
  logic               w_match;

  assign w_len_clamped = LEN_W'(clamp_len(32'(len), MAX_LEN));

  // Only the low cfg_len history bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_cfg_len);
    end
  end

  assign w_hist_next  = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_next  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_armed_next = (w_fill_next >= r_cfg_len);

  // Match is evaluated on the post-shift view so y can register it directly.
  assign w_match = en && !cfg_load && (r_state != IDLE) && w_armed_next &&
                   (((w_hist_next ^ r_cfg_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_pat <= '0;
      r_cfg_len <= '0;
      r_cfg_ovl <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= IDLE;
      r_y       <= 1'b0;
    end else if (cfg_load) begin
      r_cfg_pat <= pattern;
      r_cfg_len <= w_len_clamped;
      r_cfg_ovl <= overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= (w_len_clamped == '0) ? IDLE : FILL;
      r_y       <= 1'b0;
    end else if (en) begin
      r_hist <= w_hist_next;
      r_y    <= w_match;
      if (w_match && !r_cfg_ovl) begin
        // Non-overlapping: completed bits are consumed, refill from scratch.
        r_fill  <= '0;
        r_state <= FILL;
      end else begin
        r_fill <= w_fill_next;
        case (r_state)
          FILL:    if (w_armed_next) r_state <= ARMED;
          default: r_state <= r_state;
        endcase
      end
    end else begin
      // Gap cycle: everything frozen, pulse ends.
      r_y <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk (clk),
    .rst (rst),
    .inc (w_match),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign y = r_y;

endmodule
